// File: rtl/team_06_effect_engine.sv
// ---------------------------------------------------------------------------------------------
// team_06_effect_engine
//
// Audio-effect stage for the push-to-talk datapath. Takes the 8-bit offset-binary mic stream
// and applies echo, tremolo, reverb or soft attenuation. The effect is chosen by
// current_effect/eff_en, which are sampled on each accepted sample. Each accepted sample
// produces one processed sample one cycle later.
//
// Parameters
//   DELAY_DEPTH  echo/reverb delay in samples (power of two, 2..256)
//   TREM_DIV     accepted tremolo samples per LFO gain step (>= 1)
//
// Ports
//   clk             system clock
//   rst             synchronous active-high reset
//   in_valid        one-cycle strobe; in_sample is accepted this cycle
//   in_sample       mic sample, offset binary (128 = silence)
//   current_effect  0 NORMAL, 1 ECHO, 2 TREMOLO, 3 REVERB, 4 SOFT, 5..7 NORMAL
//   eff_en          0 forces pass-through (and freezes the LFO)
//   out_valid       one-cycle strobe marking a new out_sample
//   out_sample      processed sample, offset binary; holds between strobes
//
// Build option
//   TEAM_06_REVERB_EN  when defined, code 3 selects the reverb (feedback) path. When it is
//                      undefined, code 3 behaves as NORMAL, the delay line always stores the
//                      dry sample, and the feedback saturation logic is not built.
// ---------------------------------------------------------------------------------------------
module team_06_effect_engine #(
  parameter int unsigned DELAY_DEPTH = 64,
  parameter int unsigned TREM_DIV    = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_sample,
  input  logic [2:0] current_effect,
  input  logic       eff_en,
  output logic       out_valid,
  output logic [7:0] out_sample
);

  localparam int unsigned AddrW = $clog2(DELAY_DEPTH);
  localparam int unsigned DcW   = (TREM_DIV > 1) ? $clog2(TREM_DIV) : 1;
  localparam logic [DcW-1:0] DcLast = DcW'(TREM_DIV - 1);

  localparam logic [2:0] EffEcho    = 3'd1;
  localparam logic [2:0] EffTremolo = 3'd2;
`ifdef TEAM_06_REVERB_EN
  localparam logic [2:0] EffReverb  = 3'd3;
`endif
  localparam logic [2:0] EffSoft    = 3'd4;

  // Clamp a wide signed intermediate to the signed 8-bit sample range.
  function automatic logic signed [7:0] sat13(input logic signed [12:0] v);
    if (v > 13'sd127) begin
      return 8'sh7f;
    end else if (v < -13'sd128) begin
      return -8'sd128;
    end else begin
      return v[7:0];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic signed [7:0] dly_q [DELAY_DEPTH];
  logic [AddrW-1:0]  wp_q, wp_d;

  logic [3:0]        g_q, g_d;
  logic              dn_q, dn_d;
  logic [DcW-1:0]    dc_q, dc_d;

  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_sample_q, out_sample_d;

  // ---------------------------------------------------------------------------
  // Datapath (everything widened to 13-bit signed so no term can overflow)
  // ---------------------------------------------------------------------------
  logic signed [8:0]  s;
  logic signed [12:0] s_x;
  logic signed [7:0]  d;
  logic signed [12:0] d_half_x;
  logic signed [12:0] echo_x;
  logic [12:0]        gain_x;
  logic signed [12:0] trem_prod;
  logic signed [12:0] trem_x;
  logic signed [12:0] soft_x;

  assign s        = $signed({1'b0, in_sample}) - 9'sd128;
  assign s_x      = {{4{s[8]}}, s};

  // Combinational read of the oldest entry: the slot about to be overwritten.
  assign d        = dly_q[wp_q];
  assign d_half_x = {{6{d[7]}}, d[7:1]};
  assign echo_x   = s_x + d_half_x;

  // Tremolo gain is (g + 1) in 1..16; product fits in 13 bits signed.
  assign gain_x    = {8'b0, ({1'b0, g_q} + 5'd1)};
  assign trem_prod = s_x * $signed(gain_x);
  assign trem_x    = trem_prod >>> 4;

  assign soft_x    = s_x >>> 2;

`ifdef TEAM_06_REVERB_EN
  // Reverb feeds the saturated wet value back into the delay line.
  logic signed [7:0] rev_w;
  assign rev_w = sat13(echo_x);
`endif

  // ---------------------------------------------------------------------------
  // Effect selection
  // ---------------------------------------------------------------------------
  logic signed [12:0] y_x;
  logic signed [7:0]  st;
  logic               trem_sel;
  logic signed [7:0]  y_sat;

  always_comb begin
    y_x      = s_x;
    st       = s[7:0];
    trem_sel = 1'b0;
    if (eff_en) begin
      case (current_effect)
        EffEcho: begin
          y_x = echo_x;
        end
        EffTremolo: begin
          y_x      = trem_x;
          trem_sel = 1'b1;
        end
`ifdef TEAM_06_REVERB_EN
        EffReverb: begin
          y_x = {{5{rev_w[7]}}, rev_w};
          st  = rev_w;
        end
`endif
        EffSoft: begin
          y_x = soft_x;
        end
        default: begin
          y_x = s_x;
        end
      endcase
    end
  end

  assign y_sat = sat13(y_x);

  // ---------------------------------------------------------------------------
  // Tremolo LFO: triangle sweep of g between 15 and 0
  // ---------------------------------------------------------------------------
  logic step_down;

  // Direction actually used for this step; endpoints reverse it.
  assign step_down = dn_q ? (g_q != 4'd0) : (g_q == 4'd15);

  always_comb begin
    g_d  = g_q;
    dn_d = dn_q;
    dc_d = dc_q;
    if (in_valid && trem_sel) begin
      if (dc_q == DcLast) begin
        dc_d = '0;
        dn_d = step_down;
        g_d  = step_down ? (g_q - 4'd1) : (g_q + 4'd1);
      end else begin
        dc_d = dc_q + DcW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write pointer and output register next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wp_d         = wp_q;
    out_valid_d  = 1'b0;
    out_sample_d = out_sample_q;
    if (in_valid) begin
      // DELAY_DEPTH is a power of two, so natural wrap gives the modulo.
      wp_d         = wp_q + AddrW'(1);
      out_valid_d  = 1'b1;
      out_sample_d = {~y_sat[7], y_sat[6:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q         <= '0;
      g_q          <= 4'd15;
      dn_q         <= 1'b1;
      dc_q         <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= 8'd128;
    end else begin
      wp_q         <= wp_d;
      g_q          <= g_d;
      dn_q         <= dn_d;
      dc_q         <= dc_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY_DEPTH; i++) begin
        dly_q[i] <= '0;
      end
    end else if (in_valid) begin
      dly_q[wp_q] <= st;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;

endmodule

// File: tb/tb_team_06_effect_engine.sv
// ---------------------------------------------------------------------------------------------
// tb_team_06_effect_engine
//
// Directed bench for team_06_effect_engine built with DELAY_DEPTH = 4 and TREM_DIV = 2.
// Expected outputs are hand-computed sample values.
// ---------------------------------------------------------------------------------------------
module tb_team_06_effect_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_sample;
  logic [2:0] current_effect;
  logic       eff_en;
  logic       out_valid;
  logic [7:0] out_sample;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  team_06_effect_engine #(
    .DELAY_DEPTH (4),
    .TREM_DIV    (2)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_sample      (in_sample),
    .current_effect (current_effect),
    .eff_en         (eff_en),
    .out_valid      (out_valid),
    .out_sample     (out_sample)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One accepted sample; result is sampled 1 ns after the accepting edge.
  task automatic accept(input logic en, input logic [2:0] code, input logic [7:0] smp,
                        input logic [7:0] exp, input string tag);
    @(negedge clk);
    eff_en         = en;
    current_effect = code;
    in_sample      = smp;
    in_valid       = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check(tag, 32'(out_sample), 32'(exp));
  endtask

  // Echo stream with DELAY_DEPTH = 4, including a saturating hit and a negative echo.
  logic [7:0] echo_in  [16] = '{228, 128, 128, 128, 128, 128, 255, 128,
                                 128, 128, 255,  27, 128, 128, 128, 128};
  logic [7:0] echo_exp [16] = '{228, 128, 128, 128, 178, 128, 255, 128,
                                 128, 128, 255,  27, 128, 128, 191,  77};

`ifdef TEAM_06_REVERB_EN
  logic [7:0] rev_exp [13] = '{228, 128, 128, 128, 178, 128, 128, 128,
                               153, 128, 128, 128, 140};
`endif

  initial begin
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_sample      = 8'd128;
    current_effect = 3'd0;
    eff_en         = 1'b0;

    do_reset();
    check("reset.valid", 32'(out_valid), 32'd0);
    check("reset.sample", 32'(out_sample), 32'd128);

    // Pass-through cases
    accept(1'b1, 3'd0, 8'd200, 8'd200, "normal");
    accept(1'b1, 3'd6, 8'd200, 8'd200, "code6");
    accept(1'b0, 3'd4, 8'd200, 8'd200, "en0_soft");
    accept(1'b0, 3'd1, 8'd200, 8'd200, "en0_echo");
    @(posedge clk);
    #1;
    check("idle.valid", 32'(out_valid), 32'd0);
    check("idle.hold", 32'(out_sample), 32'd200);

    // Soft: floor toward -inf
    accept(1'b1, 3'd4, 8'd228, 8'd153, "soft_pos");
    accept(1'b1, 3'd4, 8'd27, 8'd102, "soft_neg");

    // Echo
    do_reset();
    for (int i = 0; i < 16; i++) begin
      accept(1'b1, 3'd1, echo_in[i], echo_exp[i], $sformatf("echo[%0d]", i));
    end

    // Reset mid-stream: fill history with full-scale, then reset with a strobe present
    do_reset();
    for (int i = 0; i < 4; i++) begin
      accept(1'b1, 3'd1, 8'd255, 8'd255, $sformatf("fill[%0d]", i));
    end
    accept(1'b1, 3'd1, 8'd255, 8'd255, "pre_rst");
    rst            = 1'b1;
    in_valid       = 1'b1;
    in_sample      = 8'd255;
    current_effect = 3'd1;
    eff_en         = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst.valid", 32'(out_valid), 32'd0);
    check("midrst.sample", 32'(out_sample), 32'd128);
    for (int i = 0; i < 4; i++) begin
      accept(1'b1, 3'd1, 8'd128, 8'd128, $sformatf("post_rst[%0d]", i));
    end
    accept(1'b1, 3'd1, 8'd228, 8'd228, "post_rst_imp");

    // Reverb (or NORMAL for code 3 when not built)
    do_reset();
`ifdef TEAM_06_REVERB_EN
    for (int i = 0; i < 13; i++) begin
      accept(1'b1, 3'd3, (i == 0) ? 8'd228 : 8'd128, rev_exp[i], $sformatf("reverb[%0d]", i));
    end
`else
    for (int i = 0; i < 5; i++) begin
      accept(1'b1, 3'd3, (i == 0) ? 8'd228 : 8'd128, (i == 0) ? 8'd228 : 8'd128,
             $sformatf("code3[%0d]", i));
    end
`endif

    // Tremolo, constant 228 (s = 100), two accepts per gain step
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int p;
      int g;
      logic [7:0] exp;
      // LFO must not advance on non-tremolo or disabled accepts
      if (i == 3) begin
        accept(1'b0, 3'd2, 8'd228, 8'd228, "trem_hold_en0");
        accept(1'b1, 3'd0, 8'd228, 8'd228, "trem_hold_norm");
      end
      p   = i / 2;
      g   = (p <= 15) ? (15 - p) : (p - 15);
      exp = 8'(128 + (100 * (g + 1)) / 16);
      accept(1'b1, 3'd2, 8'd228, exp, $sformatf("trem[%0d]", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
